// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller, CP0 Status/Cause/EPC and PC-redirect sequencer
// Optional INTR_IRQ_SYNC_EN: two-flop synchronizer on irq_i ahead of edge detection.
module intr_ctrl #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        pc_mem_i,
  input  logic               pc_valid_i,
  input  logic               eret_i,
  input  logic               mtc0_we_i,
  input  logic [4:0]         mtc0_addr_i,
  input  logic [31:0]        mtc0_data_i,
  input  logic [4:0]         mfc0_addr_i,
  output logic [31:0]        mfc0_data_o,
  output logic               flush_o,
  output logic [1:0]         npc_sel_o,
  output logic [31:0]        target_pc_o,
  output logic [31:0]        epc_o,
  output logic               int_active_o
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state, state_next;
  logic               status_ie;
  logic [NUM_IRQ-1:0] status_im;
  logic [NUM_IRQ-1:0] cause_ip, ip_next;
  logic [4:0]         cause_code;
  logic [31:0]        epc;
  logic [NUM_IRQ-1:0] irq_src, irq_prev, new_edge;
  logic [NUM_IRQ-1:0] pend, win_mask;
  logic [4:0]         win_idx;
  logic               req, ret_go, take_go;
  logic               wr_status, wr_cause, wr_epc;
  logic               unused_data_bits;

`ifdef INTR_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta, irq_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= irq_i;
      irq_sync <= irq_meta;
    end
  end
  assign irq_src = irq_sync;
`else
  assign irq_src = irq_i;
`endif

  assign new_edge  = irq_src & ~irq_prev;
  assign pend      = cause_ip & status_im;
  assign req       = status_ie & (|pend);
  assign wr_status = mtc0_we_i && (mtc0_addr_i == REG_STATUS);
  assign wr_cause  = mtc0_we_i && (mtc0_addr_i == REG_CAUSE);
  assign wr_epc    = mtc0_we_i && (mtc0_addr_i == REG_EPC);
  assign unused_data_bits = ^{mtc0_data_i[31:8+NUM_IRQ], mtc0_data_i[7:1]};

  // Lowest index wins: scan downward so the last hit is the smallest k.
  always_comb begin
    win_idx  = '0;
    win_mask = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        win_idx  = 5'(k);
        win_mask = NUM_IRQ'(1) << k;
      end
    end
  end

  // Redirects are suppressed in a reset cycle; ERET outranks a pending take.
  always_comb begin
    state_next  = state;
    ret_go      = 1'b0;
    take_go     = 1'b0;
    flush_o     = 1'b0;
    npc_sel_o   = 2'b00;
    target_pc_o = 32'h0;
    if (!rst && pc_valid_i) begin
      if (eret_i) begin
        ret_go      = 1'b1;
        flush_o     = 1'b1;
        npc_sel_o   = 2'b10;
        target_pc_o = epc;
        state_next  = IDLE;
      end else if (state == IDLE && req) begin
        take_go     = 1'b1;
        flush_o     = 1'b1;
        npc_sel_o   = 2'b01;
        target_pc_o = HANDLER_ADDR;
        state_next  = SERVICE;
      end
    end
  end

  // A fresh edge re-sets IP even when it is being cleared this cycle.
  always_comb begin
    ip_next = cause_ip;
    if (wr_cause) ip_next = ip_next & ~mtc0_data_i[8 +: NUM_IRQ];
    if (take_go)  ip_next = ip_next & ~win_mask;
    ip_next = ip_next | new_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      status_ie  <= 1'b0;
      status_im  <= '0;
      cause_ip   <= '0;
      cause_code <= '0;
      epc        <= '0;
      irq_prev   <= '0;
    end else begin
      state    <= state_next;
      irq_prev <= irq_src;
      cause_ip <= ip_next;
      if (wr_status) begin
        status_im <= mtc0_data_i[8 +: NUM_IRQ];
        status_ie <= mtc0_data_i[0];
      end
      if (take_go)     status_ie <= 1'b0;
      else if (ret_go) status_ie <= 1'b1;
      if (wr_epc)  epc <= mtc0_data_i;
      if (take_go) begin
        epc        <= pc_mem_i;
        cause_code <= win_idx;
      end
    end
  end

  always_comb begin
    mfc0_data_o = 32'h0;
    case (mfc0_addr_i)
      REG_STATUS: begin
        mfc0_data_o[0]            = status_ie;
        mfc0_data_o[8 +: NUM_IRQ] = status_im;
      end
      REG_CAUSE: begin
        mfc0_data_o[6:2]          = cause_code;
        mfc0_data_o[8 +: NUM_IRQ] = cause_ip;
      end
      REG_EPC:  mfc0_data_o = epc;
      default:  mfc0_data_o = 32'h0;
    endcase
  end

  assign epc_o        = epc;
  assign int_active_o = (state == SERVICE);

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed scoreboard bench for intr_ctrl
module tb_intr_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_i;
  logic [31:0]   pc_mem_i;
  logic          pc_valid_i;
  logic          eret_i;
  logic          mtc0_we_i;
  logic [4:0]    mtc0_addr_i;
  logic [31:0]   mtc0_data_i;
  logic [4:0]    mfc0_addr_i;
  logic [31:0]   mfc0_data_o;
  logic          flush_o;
  logic [1:0]    npc_sel_o;
  logic [31:0]   target_pc_o;
  logic [31:0]   epc_o;
  logic          int_active_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  intr_ctrl #(.NUM_IRQ(N), .HANDLER_ADDR(32'h0000_4180)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .pc_mem_i(pc_mem_i),
    .pc_valid_i(pc_valid_i), .eret_i(eret_i), .mtc0_we_i(mtc0_we_i),
    .mtc0_addr_i(mtc0_addr_i), .mtc0_data_i(mtc0_data_i),
    .mfc0_addr_i(mfc0_addr_i), .mfc0_data_o(mfc0_data_o),
    .flush_o(flush_o), .npc_sel_o(npc_sel_o), .target_pc_o(target_pc_o),
    .epc_o(epc_o), .int_active_o(int_active_o)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] e);
    push(e);
    mfc0_addr_i = a;
    #1;
    chk(tag, mfc0_data_o);
  endtask

  task automatic redir_chk(input string tag, input logic f, input logic [1:0] sel,
                           input logic [31:0] tgt);
    push({31'h0, f});
    push({30'h0, sel});
    #1;
    chk({tag, ".flush"}, {31'h0, flush_o});
    chk({tag, ".sel"}, {30'h0, npc_sel_o});
    if (sel != 2'b00) begin
      push(tgt);
      chk({tag, ".target"}, target_pc_o);
    end
  endtask

  task automatic state_chk(input string tag, input logic act, input logic [31:0] e_epc);
    push({31'h0, act});
    push(e_epc);
    chk({tag, ".active"}, {31'h0, int_active_o});
    chk({tag, ".epc"}, epc_o);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we_i = 1'b1; mtc0_addr_i = a; mtc0_data_i = d;
    tick;
    mtc0_we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_i = '0; pc_mem_i = 32'h0; pc_valid_i = 1'b0; eret_i = 1'b0;
    mtc0_we_i = 1'b0; mtc0_addr_i = 5'd0; mtc0_data_i = 32'h0; mfc0_addr_i = 5'd0;
    tick; tick;
    rst = 1'b0;

    // Reset state
    redir_chk("rst", 1'b0, 2'b00, 32'h0);
    state_chk("rst", 1'b0, 32'h0);
    rd_chk("rst.status", 5'd12, 32'h0);
    rd_chk("rst.cause", 5'd13, 32'h0);
    rd_chk("rst.epc", 5'd14, 32'h0);

    // 1: take IRQ1
    mtc0(5'd12, 32'h0000_0301);
    rd_chk("t1.status", 5'd12, 32'h0000_0301);
    irq_i = 4'b0010;
    tick;
    irq_i = '0;
    rd_chk("t1.cause_pend", 5'd13, 32'h0000_0200);
    redir_chk("t1.novalid", 1'b0, 2'b00, 32'h0);
    pc_mem_i = 32'h0000_3010; pc_valid_i = 1'b1;
    redir_chk("t1.take", 1'b1, 2'b01, 32'h0000_4180);
    tick;
    pc_valid_i = 1'b0;
    state_chk("t1.post", 1'b1, 32'h0000_3010);
    rd_chk("t1.cause", 5'd13, 32'h0000_0004);
    rd_chk("t1.status_ie0", 5'd12, 32'h0000_0300);

    // 2: return
    eret_i = 1'b1; pc_valid_i = 1'b1; pc_mem_i = 32'h0000_5000;
    redir_chk("t2.eret", 1'b1, 2'b10, 32'h0000_3010);
    tick;
    eret_i = 1'b0; pc_valid_i = 1'b0;
    state_chk("t2.post", 1'b0, 32'h0000_3010);
    rd_chk("t2.status_ie1", 5'd12, 32'h0000_0301);

    // 3: simultaneous IRQ0/IRQ2, lowest index first
    mtc0(5'd12, 32'h0000_0501);
    irq_i = 4'b0101;
    tick;
    irq_i = '0;
    rd_chk("t3.cause_pend", 5'd13, 32'h0000_0504);
    pc_mem_i = 32'h0000_3100; pc_valid_i = 1'b1;
    redir_chk("t3.take0", 1'b1, 2'b01, 32'h0000_4180);
    tick;
    pc_valid_i = 1'b0;
    rd_chk("t3.cause0", 5'd13, 32'h0000_0400);
    state_chk("t3.svc", 1'b1, 32'h0000_3100);
    mtc0(5'd12, 32'h0000_0501);
    redir_chk("t3.svc_noreq", 1'b0, 2'b00, 32'h0);
    eret_i = 1'b1; pc_valid_i = 1'b1;
    redir_chk("t3.eret", 1'b1, 2'b10, 32'h0000_3100);
    tick;
    eret_i = 1'b0; pc_mem_i = 32'h0000_3200;
    redir_chk("t3.take2", 1'b1, 2'b01, 32'h0000_4180);
    tick;
    pc_valid_i = 1'b0;
    state_chk("t3.svc2", 1'b1, 32'h0000_3200);
    rd_chk("t3.cause2", 5'd13, 32'h0000_0008);
    eret_i = 1'b1; pc_valid_i = 1'b1;
    tick;
    eret_i = 1'b0; pc_valid_i = 1'b0;

    // 4: pending with no valid victim for three cycles
    irq_i = 4'b0001;
    tick;
    irq_i = '0;
    for (int i = 0; i < 3; i++) begin
      pc_mem_i = 32'h0000_3300 + 32'(i);
      redir_chk("t4.hold", 1'b0, 2'b00, 32'h0);
      tick;
    end
    pc_mem_i = 32'h0000_3400; pc_valid_i = 1'b1;
    redir_chk("t4.take", 1'b1, 2'b01, 32'h0000_4180);
    tick;
    pc_valid_i = 1'b0;
    state_chk("t4.svc", 1'b1, 32'h0000_3400);
    eret_i = 1'b1; pc_valid_i = 1'b1;
    tick;
    eret_i = 1'b0;

    // 5: masked level-held IRQ3, W1C, then unmask without new edge
    irq_i = 4'b1000; pc_mem_i = 32'h0000_3500;
    for (int i = 0; i < 10; i++) begin
      redir_chk("t5.masked", 1'b0, 2'b00, 32'h0);
      tick;
    end
    rd_chk("t5.cause_ip3", 5'd13, 32'h0000_0800);
    mtc0(5'd13, 32'h0000_0800);
    rd_chk("t5.cause_w1c", 5'd13, 32'h0000_0000);
    mtc0(5'd12, 32'h0000_0D01);
    rd_chk("t5.status", 5'd12, 32'h0000_0D01);
    redir_chk("t5.noedge", 1'b0, 2'b00, 32'h0);
    tick;
    redir_chk("t5.noedge2", 1'b0, 2'b00, 32'h0);
    irq_i = '0; pc_valid_i = 1'b0;
    tick;

    // 6: ERET beats req, then take, then reset mid-service
    irq_i = 4'b0001;
    tick;
    irq_i = '0;
    eret_i = 1'b1; pc_valid_i = 1'b1; pc_mem_i = 32'h0000_3600;
    redir_chk("t6.eret_wins", 1'b1, 2'b10, 32'h0000_3400);
    tick;
    eret_i = 1'b0; pc_mem_i = 32'h0000_3604;
    redir_chk("t6.take", 1'b1, 2'b01, 32'h0000_4180);
    tick;
    state_chk("t6.svc", 1'b1, 32'h0000_3604);
    rst = 1'b1; eret_i = 1'b1;
    redir_chk("t6.rst_noredir", 1'b0, 2'b00, 32'h0);
    tick;
    rst = 1'b0; eret_i = 1'b0; pc_valid_i = 1'b0;
    state_chk("t6.post_rst", 1'b0, 32'h0);
    rd_chk("t6.status", 5'd12, 32'h0);
    rd_chk("t6.cause", 5'd13, 32'h0);
    rd_chk("t6.epc", 5'd14, 32'h0);
    rd_chk("t6.other", 5'd3, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Interrupt controller and PC-redirect sequencer for the pipelined MIPS core with interrupts. Latches external IRQ edges, applies the Status mask and priority, and picks the MEM-stage instruction as victim. On a taken interrupt it flushes the pipe, steers fetch to the handler and saves EPC; on ERET it restores the saved PC. Holds the CP0 Status (12), Cause (13) and EPC (14) registers.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..8)
HANDLER_ADDR, 32'h0000_4180, fixed handler entry PC

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
irq_i  in  NUM_IRQ  external interrupt levels, rising-edge sensitive
pc_mem_i  in  32  PC of the instruction in MEM stage
pc_valid_i  in  1  MEM stage holds a real, non-bubble instruction
eret_i  in  1  ERET is in MEM stage (qualified by pc_valid_i)
mtc0_we_i  in  1  CP0 write strobe
mtc0_addr_i  in  5  CP0 write register number
mtc0_data_i  in  32  CP0 write data
mfc0_addr_i  in  5  CP0 read register number
mfc0_data_o  out  32  CP0 read data, combinational
flush_o  out  1  flush IF/ID/EX/MEM this cycle
npc_sel_o  out  2  00 normal, 01 handler, 10 EPC
target_pc_o  out  32  redirect PC, valid when npc_sel_o != 00
epc_o  out  32  current EPC
int_active_o  out  1  state == SERVICE

Behaviour:
- Reset (rst=1 at a clock edge): Status=0, Cause=0, EPC=0, irq_prev=0, state=IDLE. All outputs are then 0 (mfc0_data_o is 0 for all addresses).
- Status: bit0 = IE, bits[8+NUM_IRQ-1:8] = IM. All other bits read 0 and ignore writes.
- Cause: bits[8+NUM_IRQ-1:8] = IP (pending), bits[6:2] = index of the last taken IRQ. Other bits read 0.
- Edge latch: IP[k] sets on the cycle irq_i[k]=1 while irq_prev[k]=0. irq_prev is irq_i registered each cycle.
- Clearing IP: IP[k] clears when IRQ k is taken, or on an mtc0 to Cause with data bit (8+k)=1 (write-1-to-clear). A same-cycle new edge wins over either clear.
- req = IE & |(IP & IM). Winner = lowest index k with IP[k] & IM[k].
- State machine, IDLE and SERVICE:
  - IDLE, eret_i & pc_valid_i: return path. Combinational flush_o=1, npc_sel_o=10, target_pc_o=EPC. Next edge: IE<=1. State stays IDLE.
  - IDLE, req & pc_valid_i & !eret_i: take path. Combinational flush_o=1, npc_sel_o=01, target_pc_o=HANDLER_ADDR. Next edge: EPC<=pc_mem_i, IE<=0, Cause[6:2]<=k, IP[k] cleared, state<=SERVICE.
  - IDLE, req & !pc_valid_i: hold, no output. Retry every cycle until a valid victim arrives.
  - SERVICE: interrupts are not taken, even if software sets IE. IP keeps latching edges.
  - SERVICE, eret_i & pc_valid_i: return path as above, then state<=IDLE.
- Redirect latency: 0 cycles (Mealy outputs). The earliest new take is the cycle after the return completes.
- ERET and req in the same cycle: ERET wins. The interrupt is evaluated next cycle.
- CP0 write priority:
  - mtc0 to Status in a take cycle: IM bits update, IE is forced to 0.
  - mtc0 to EPC in a take cycle: the take's EPC capture wins.
  - mtc0 to Status in a return cycle: IE is forced to 1.
- mfc0_data_o: Status, Cause or EPC by mfc0_addr_i. Any other address reads 0. Reads return pre-edge values.
- epc_o mirrors EPC. int_active_o = (state==SERVICE).
- rst mid-SERVICE or mid-redirect: everything returns to reset values at that edge. No redirect is issued in the reset cycle.

Optional Feature:
INTR_IRQ_SYNC_EN
- Defined: irq_i passes through a 2-flop synchronizer (reset to 0) before edge detection. Edge-to-IP latency is 3 cycles.
- Undefined: irq_i feeds edge detection directly. Edge-to-IP latency is 1 cycle.
- All other behaviour is identical.

Test Plan:
1. Reset, then mtc0 Status=32'h0000_0301 (IE=1, IM=3), pulse irq_i[1], pc_mem_i=32'h0000_3010, pc_valid_i=1 -> take cycle: flush_o=1, npc_sel_o=01, target_pc_o=32'h0000_4180. Next cycle: epc_o=32'h0000_3010, Cause[6:2]=1, IE=0, int_active_o=1.
2. In SERVICE, assert eret_i with pc_valid_i=1 -> flush_o=1, npc_sel_o=10, target_pc_o=32'h0000_3010. Next cycle: IE=1, int_active_o=0.
3. irq_i[0] and irq_i[2] rise in the same cycle, IM=4'b0101, IE=1 -> IRQ0 taken with Cause[6:2]=0. IP[2] stays set; IRQ2 is taken on the first valid cycle after ERET.
4. Pending enabled IRQ with pc_valid_i=0 for 3 cycles, then 1 -> no flush for 3 cycles. Take on cycle 4 with EPC equal to pc_mem_i of cycle 4.
5. irq_i[3] held high for 10 cycles with IM[3]=0 -> IP[3]=1, no take. mtc0 Cause=32'h0000_0800 -> IP[3]=0. Set IM[3]=1 -> no take, because there is no new edge.
6. req and eret_i in the same IDLE cycle -> npc_sel_o=10 only. Interrupt taken next valid cycle. Assert rst in SERVICE -> Status, Cause and EPC read 0, int_active_o=0.
